// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC generator.
// PC_ALIGN_CHECK_EN enables target alignment checking in pc_gen.
package pc_pkg;

   localparam int          XLEN_DEF      = 32;
   localparam logic [31:0] RESET_VEC_DEF = 32'h1000_0000;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HOLD
   } state_e;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_PRED,
      SRC_REDIR,
      SRC_TRAP
   } src_e;

endpackage

// File: rtl/pc_pend_reg.sv
// Pending-redirect holder: keeps the highest-priority redirect seen while stalled.
// merge_* is the value the holder would take this cycle; pc_gen also uses it on release.
module pc_pend_reg
   import pc_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ld,
   input  logic            clr,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_target,
   input  logic            trap_mis,
   input  logic            redir_valid,
   input  logic [XLEN-1:0] redir_target,
   input  logic            redir_mis,
   output logic            valid,
   output logic [XLEN-1:0] target,
   output logic            mis,
   output logic [XLEN-1:0] merge_target,
   output logic            merge_mis
);

   src_e src;
   src_e merge_src;
   logic merge_valid;

   // A trap always wins; a redirect never displaces a held trap.
   always_comb begin
      merge_valid  = valid;
      merge_target = target;
      merge_mis    = mis;
      merge_src    = src;
      unique case (1'b1)
         trap_valid: begin
            merge_valid  = 1'b1;
            merge_target = trap_target;
            merge_mis    = trap_mis;
            merge_src    = SRC_TRAP;
         end
         !trap_valid && redir_valid && (src != SRC_TRAP): begin
            merge_valid  = 1'b1;
            merge_target = redir_target;
            merge_mis    = redir_mis;
            merge_src    = SRC_REDIR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         valid  <= 1'b0;
         target <= '0;
         mis    <= 1'b0;
         src    <= SRC_NONE;
      end else if (ld) begin
         valid  <= merge_valid;
         target <= merge_target;
         mis    <= merge_mis;
         src    <= merge_src;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: trap > redirect > predicted > sequential.
// Define PC_ALIGN_CHECK_EN to align targets and flag misaligned redirects.
module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN       = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(RESET_VEC_DEF),
   parameter int              INST_BYTES = 4,
   parameter int              NUM_STALL  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_STALL-1:0] stall_i,
   input  logic                 fetch_ready,
   input  logic                 trap_valid,
   input  logic [XLEN-1:0]      trap_target,
   input  logic                 redir_valid,
   input  logic [XLEN-1:0]      redir_target,
   input  logic                 pred_taken,
   input  logic [XLEN-1:0]      pred_target,
   output logic [XLEN-1:0]      pc_o,
   output logic                 fetch_valid,
   output logic                 flush_o,
   output logic                 pend_o,
   output logic                 misalign_o
);

   localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);

   state_e          state;
   logic [XLEN-1:0] pc_q;
   logic            flush_q;
   logic            mis_q;

   logic            stall;
   logic            req;
   logic [XLEN-1:0] trap_t;
   logic [XLEN-1:0] redir_t;
   logic            trap_mis;
   logic            redir_mis;
   logic            pred_ok;

   logic            pend_ld;
   logic            pend_clr;
   logic            pend_valid;
   logic [XLEN-1:0] pend_target;
   logic            pend_mis;
   logic [XLEN-1:0] merge_target;
   logic            merge_mis;

   assign stall = |stall_i;
   assign req   = trap_valid | redir_valid;

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [XLEN-1:0] OFS = XLEN'(INST_BYTES - 1);

   assign trap_t    = trap_target & ~OFS;
   assign redir_t   = redir_target & ~OFS;
   assign trap_mis  = |(trap_target & OFS);
   assign redir_mis = |(redir_target & OFS);
   assign pred_ok   = ~|(pred_target & OFS);
`else
   assign trap_t    = trap_target;
   assign redir_t   = redir_target;
   assign trap_mis  = 1'b0;
   assign redir_mis = 1'b0;
   assign pred_ok   = 1'b1;
`endif

   // Capture while stalled; drain on the first unstalled HOLD cycle.
   assign pend_ld  = stall & (((state == RUN) & req) | (state == HOLD));
   assign pend_clr = (state == HOLD) & ~stall;

   pc_pend_reg #(
      .XLEN (XLEN)
   ) u_pend (
      .clk          (clk),
      .rst_n        (rst_n),
      .ld           (pend_ld),
      .clr          (pend_clr),
      .trap_valid   (trap_valid),
      .trap_target  (trap_t),
      .trap_mis     (trap_mis),
      .redir_valid  (redir_valid),
      .redir_target (redir_t),
      .redir_mis    (redir_mis),
      .valid        (pend_valid),
      .target       (pend_target),
      .mis          (pend_mis),
      .merge_target (merge_target),
      .merge_mis    (merge_mis)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= BOOT;
         pc_q    <= RESET_VEC;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
         unique case (state)
            BOOT: state <= RUN;
            RUN: begin
               if (!stall) begin
                  if (trap_valid) begin
                     pc_q    <= trap_t;
                     flush_q <= 1'b1;
                     mis_q   <= trap_mis;
                  end else if (redir_valid) begin
                     pc_q    <= redir_t;
                     flush_q <= 1'b1;
                     mis_q   <= redir_mis;
                  end else if (fetch_ready) begin
                     if (pred_taken && pred_ok)
                        pc_q <= pred_target;
                     else
                        pc_q <= pc_q + STEP;
                  end
               end else if (req) begin
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (!stall) begin
                  pc_q    <= merge_target;
                  flush_q <= 1'b1;
                  mis_q   <= merge_mis;
                  state   <= RUN;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   assign pc_o        = pc_q;
   assign fetch_valid = (state == RUN) & ~stall;
   assign flush_o     = flush_q;
   assign pend_o      = pend_valid;
   assign misalign_o  = mis_q;

   logic unused_pend;
   assign unused_pend = ^{pend_target, pend_mis};

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected outputs queued per cycle, popped after the edge.
// Honours PC_ALIGN_CHECK_EN for the alignment cases.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  stall_i;
   logic        fetch_ready;
   logic        trap_valid;
   logic [31:0] trap_target;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [31:0] pc_o;
   logic        fetch_valid;
   logic        flush_o;
   logic        pend_o;
   logic        misalign_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        fl;
      logic        pd;
      logic        mi;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pc_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall_i),
      .fetch_ready  (fetch_ready),
      .trap_valid   (trap_valid),
      .trap_target  (trap_target),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .pred_taken   (pred_taken),
      .pred_target  (pred_target),
      .pc_o         (pc_o),
      .fetch_valid  (fetch_valid),
      .flush_o      (flush_o),
      .pend_o       (pend_o),
      .misalign_o   (misalign_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input string tag, input logic [31:0] pc,
                       input logic fv, input logic fl,
                       input logic pd, input logic mi);
      exp_t e;
      e = '{pc, fv, fl, pd, mi};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, ".pc"}, pc_o, e.pc);
         chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, e.fv});
         chk({tag, ".flush"}, {31'd0, flush_o}, {31'd0, e.fl});
         chk({tag, ".pend"}, {31'd0, pend_o}, {31'd0, e.pd});
         chk({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, e.mi});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a_pc;
      logic        a_mi;
      logic [31:0] p_pc;

      rst_n        = 1'b0;
      stall_i      = 2'b00;
      fetch_ready  = 1'b1;
      trap_valid   = 1'b0;
      trap_target  = '0;
      redir_valid  = 1'b0;
      redir_target = '0;
      pred_taken   = 1'b0;
      pred_target  = '0;

      tick("rst", 32'h1000_0000, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick("boot", 32'h1000_0000, 1, 0, 0, 0);
      tick("seq1", 32'h1000_0004, 1, 0, 0, 0);
      tick("seq2", 32'h1000_0008, 1, 0, 0, 0);

      pred_taken  = 1'b1;
      pred_target = 32'h1000_0100;
      fetch_ready = 1'b0;
      tick("pred_nrdy", 32'h1000_0008, 1, 0, 0, 0);
      fetch_ready = 1'b1;
      tick("pred", 32'h1000_0100, 1, 0, 0, 0);
      pred_taken = 1'b0;
      tick("seq3", 32'h1000_0104, 1, 0, 0, 0);

      trap_valid   = 1'b1;
      trap_target  = 32'h0000_0080;
      redir_valid  = 1'b1;
      redir_target = 32'h1000_0200;
      tick("trap_redir", 32'h0000_0080, 1, 1, 0, 0);
      trap_valid  = 1'b0;
      redir_valid = 1'b0;
      tick("post_trap", 32'h0000_0084, 1, 0, 0, 0);

      stall_i      = 2'b10;
      redir_valid  = 1'b1;
      redir_target = 32'h1000_0300;
      tick("h1_c1", 32'h0000_0084, 0, 0, 1, 0);
      redir_valid = 1'b0;
      tick("h1_c2", 32'h0000_0084, 0, 0, 1, 0);
      trap_valid  = 1'b1;
      trap_target = 32'h0000_0080;
      tick("h1_c3", 32'h0000_0084, 0, 0, 1, 0);
      trap_valid = 1'b0;
      tick("h1_c4", 32'h0000_0084, 0, 0, 1, 0);
      stall_i = 2'b00;
      tick("h1_rel", 32'h0000_0080, 1, 1, 0, 0);
      tick("h1_seq", 32'h0000_0084, 1, 0, 0, 0);

      stall_i    = 2'b10;
      trap_valid = 1'b1;
      tick("h2_c1", 32'h0000_0084, 0, 0, 1, 0);
      trap_valid = 1'b0;
      tick("h2_c2", 32'h0000_0084, 0, 0, 1, 0);
      redir_valid = 1'b1;
      tick("h2_c3", 32'h0000_0084, 0, 0, 1, 0);
      redir_valid = 1'b0;
      tick("h2_c4", 32'h0000_0084, 0, 0, 1, 0);
      stall_i = 2'b00;
      tick("h2_rel", 32'h0000_0080, 1, 1, 0, 0);
      tick("h2_seq", 32'h0000_0084, 1, 0, 0, 0);

      stall_i      = 2'b01;
      redir_valid  = 1'b1;
      redir_target = 32'h1000_0300;
      tick("h3_c1", 32'h0000_0084, 0, 0, 1, 0);
      stall_i      = 2'b00;
      redir_target = 32'h1000_0400;
      tick("h3_rel", 32'h1000_0400, 1, 1, 0, 0);
      redir_valid = 1'b0;
      tick("h3_seq", 32'h1000_0404, 1, 0, 0, 0);

      stall_i    = 2'b01;
      trap_valid = 1'b1;
      tick("h4_c1", 32'h1000_0404, 0, 0, 1, 0);
      stall_i      = 2'b00;
      trap_valid   = 1'b0;
      redir_valid  = 1'b1;
      redir_target = 32'h1000_0500;
      tick("h4_rel", 32'h0000_0080, 1, 1, 0, 0);
      redir_valid = 1'b0;
      tick("h4_seq", 32'h0000_0084, 1, 0, 0, 0);

      redir_valid  = 1'b1;
      redir_target = 32'hFFFF_FFFC;
      tick("to_top", 32'hFFFF_FFFC, 1, 1, 0, 0);
      redir_valid = 1'b0;
      tick("wrap", 32'h0000_0000, 1, 0, 0, 0);
      tick("wrap_seq", 32'h0000_0004, 1, 0, 0, 0);

      stall_i      = 2'b10;
      redir_valid  = 1'b1;
      redir_target = 32'h1000_0600;
      tick("rh_hold", 32'h0000_0004, 0, 0, 1, 0);
      redir_valid = 1'b0;
      rst_n       = 1'b0;
      tick("rh_rst", 32'h1000_0000, 0, 0, 0, 0);
      rst_n   = 1'b1;
      stall_i = 2'b00;
      tick("rh_boot", 32'h1000_0000, 1, 0, 0, 0);
      tick("rh_seq", 32'h1000_0004, 1, 0, 0, 0);

`ifdef PC_ALIGN_CHECK_EN
      a_pc = 32'h1000_0300;
      a_mi = 1'b1;
`else
      a_pc = 32'h1000_0302;
      a_mi = 1'b0;
`endif
      redir_valid  = 1'b1;
      redir_target = 32'h1000_0302;
      tick("al_redir", a_pc, 1, 1, 0, a_mi);
      redir_valid = 1'b0;
      a_pc        = a_pc + 32'd4;
      tick("al_seq", a_pc, 1, 0, 0, 0);

`ifdef PC_ALIGN_CHECK_EN
      p_pc = a_pc + 32'd4;
`else
      p_pc = 32'h1000_0402;
`endif
      pred_taken  = 1'b1;
      pred_target = 32'h1000_0402;
      tick("al_pred", p_pc, 1, 0, 0, 0);
      pred_taken = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
